// File: rtl/bcd_price_alu_seq.sv
// rtl/bcd_price_alu_seq.sv - digit-serial BCD price add/sub sequencer with saturation
//
// Computes a +/- b on 5-digit BCD prices (3 dollar + 2 cent digits), one
// BCD digit per cycle, LSD first, through a single 4-bit add/sub cell.
//
// Ports:
//   clk        clock
//   arst_n     asynchronous active-low reset
//   in_vld     operation request valid
//   in_rdy     block can accept an operation (IDLE only)
//   in_op      0 = add (a + b), 1 = subtract (a - b)
//   in_a       operand A, packed BCD price
//   in_b       operand B, packed BCD price
//   out_vld    result valid (DONE only)
//   out_rdy    consumer accepts result
//   out_price  result price, packed BCD
//   out_sat    overflow (add) or underflow (sub) occurred
//   out_err    an operand contained a non-BCD digit
//
// Parameters:
//   SAT_EN     1: clamp to PRICE_MAX / PRICE_MIN on overflow/underflow
//              0: wrap modulo 10^N_DIGITS (out_sat still raised)
//   N_DIGITS   number of BCD digits; only 5 is supported

module bcd_price_alu_seq #(
  parameter bit SAT_EN   = 1'b1,
  parameter int N_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic                    in_op,
  input  logic [4*N_DIGITS-1:0]   in_a,
  input  logic [4*N_DIGITS-1:0]   in_b,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [4*N_DIGITS-1:0]   out_price,
  output logic                    out_sat,
  output logic                    out_err
);

  localparam int              W         = 4 * N_DIGITS;
  localparam logic [2:0]      LAST_IDX  = 3'(N_DIGITS - 1);
  localparam logic [W-1:0]    PRICE_MAX = {N_DIGITS{4'h9}};
  localparam logic [W-1:0]    PRICE_MIN = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured operation. Operands are shifted right one digit per CALC
  // cycle so the digit cell always reads the low nibble.
  logic          op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic          carry_q;
  logic [2:0]    idx_q;
  logic          err_q;

  // Registered result, stable for the whole DONE phase.
  logic [W-1:0]  out_price_q;
  logic          out_sat_q;
  logic          out_err_q;

  logic          accept;
  logic          last_digit;
  logic          in_err;

  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [5:0]    dig_sum;
  logic [5:0]    dig_diff;
  logic [3:0]    cell_digit;
  logic          cell_carry;
  logic [W-1:0]  result_next;
  logic [W-1:0]  fin_price;
  logic          fin_sat;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_rdy / out_vld depend on state only, so there is no combinational
  // path from in_vld or out_rdy into either handshake output.
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_vld    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign last_digit = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // Operand validity: any nibble above 9 in either operand poisons the op.
  // ---------------------------------------------------------------------
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (in_a[4*i +: 4] > 4'd9 || in_b[4*i +: 4] > 4'd9) begin
        in_err = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Single-digit BCD add/sub cell. Six bits give headroom for non-BCD
  // digits (sum up to 31) and a clean sign bit for the subtract path
  // (difference down to -16).
  // ---------------------------------------------------------------------
  assign dig_a = a_q[3:0];
  assign dig_b = b_q[3:0];

  always_comb begin
    dig_sum    = {2'b00, dig_a} + {2'b00, dig_b} + {5'b00000, carry_q};
    dig_diff   = {2'b00, dig_a} - {2'b00, dig_b} - {5'b00000, carry_q};
    cell_digit = 4'd0;
    cell_carry = 1'b0;
    if (!op_q) begin
      if (dig_sum > 6'd9) begin
        cell_digit = 4'(dig_sum - 6'd10);
        cell_carry = 1'b1;
      end else begin
        cell_digit = dig_sum[3:0];
      end
    end else begin
      if (dig_diff[5]) begin
        cell_digit = 4'(dig_diff + 6'd10);
        cell_carry = 1'b1;
      end else begin
        cell_digit = dig_diff[3:0];
      end
    end
  end

  // New digit enters at the top; after N_DIGITS shifts digit 0 sits in
  // the low nibble.
  assign result_next = {cell_digit, res_q[W-1:4]};

  // Final result selection, evaluated on the last CALC cycle where
  // cell_carry is the overall carry/borrow out of the MSD.
  always_comb begin
    fin_price = result_next;
    fin_sat   = 1'b0;
    if (err_q) begin
      fin_price = PRICE_MIN;
      fin_sat   = 1'b0;
    end else if (cell_carry) begin
      fin_sat = 1'b1;
      if (SAT_EN) begin
        fin_price = op_q ? PRICE_MIN : PRICE_MAX;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= 3'd0;
      err_q       <= 1'b0;
      out_price_q <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= in_op;
        a_q     <= in_a;
        b_q     <= in_b;
        err_q   <= in_err;
        res_q   <= '0;
        carry_q <= 1'b0;
        idx_q   <= 3'd0;
      end else if (state == CALC) begin
        a_q     <= {4'd0, a_q[W-1:4]};
        b_q     <= {4'd0, b_q[W-1:4]};
        res_q   <= result_next;
        carry_q <= cell_carry;
        idx_q   <= idx_q + 3'd1;
        if (last_digit) begin
          out_price_q <= fin_price;
          out_sat_q   <= fin_sat;
          out_err_q   <= err_q;
        end
      end
    end
  end

  assign out_price = out_price_q;
  assign out_sat   = out_sat_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_price_alu_seq.sv
// tb/tb_bcd_price_alu_seq.sv - self-checking bench for bcd_price_alu_seq (SAT_EN=1 and SAT_EN=0)

module tb_bcd_price_alu_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic        in_vld;
  logic        in_op;
  logic [19:0] in_a;
  logic [19:0] in_b;
  logic        out_rdy;

  logic        in_rdy1, out_vld1, out_sat1, out_err1;
  logic [19:0] out_price1;
  logic        in_rdy0, out_vld0, out_sat0, out_err0;
  logic [19:0] out_price0;

  bcd_price_alu_seq #(.SAT_EN(1'b1), .N_DIGITS(5)) u_sat (
    .clk(clk), .arst_n(arst_n),
    .in_vld(in_vld), .in_rdy(in_rdy1), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_vld(out_vld1), .out_rdy(out_rdy),
    .out_price(out_price1), .out_sat(out_sat1), .out_err(out_err1)
  );

  bcd_price_alu_seq #(.SAT_EN(1'b0), .N_DIGITS(5)) u_wrap (
    .clk(clk), .arst_n(arst_n),
    .in_vld(in_vld), .in_rdy(in_rdy0), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_vld(out_vld0), .out_rdy(out_rdy),
    .out_price(out_price0), .out_sat(out_sat0), .out_err(out_err0)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [21:0] exp1;     // {err, sat, price} for SAT_EN=1
  logic [21:0] exp0;     // {err, sat, price} for SAT_EN=0
  logic        pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int bcd2int(input logic [19:0] v);
    int r = 0;
    for (int i = 4; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [19:0] int2bcd(input int v);
    logic [19:0] r = '0;
    int          x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: decimal arithmetic on the integer values of the prices.
  function automatic logic [21:0] model(input logic op, input logic [19:0] a,
                                        input logic [19:0] b, input logic sat_en);
    logic err = 1'b0;
    int   r;
    for (int i = 0; i < 5; i++)
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) err = 1'b1;
    if (err) return {1'b1, 1'b0, 20'h00000};
    r = op ? bcd2int(a) - bcd2int(b) : bcd2int(a) + bcd2int(b);
    if (r > 99999) return {1'b0, 1'b1, sat_en ? 20'h99999 : int2bcd(r - 100000)};
    if (r < 0)     return {1'b0, 1'b1, sat_en ? 20'h00000 : int2bcd(r + 100000)};
    return {2'b00, int2bcd(r)};
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Compare process: every cycle a result is presented, both DUTs must
  // match the model for the operation in flight.
  always @(negedge clk) begin
    if (arst_n) begin
      if (out_vld1) begin
        check("vld1_has_op", {31'd0, pending}, 32'd1);
        if (pending) begin
          check("cmp1_price", {12'd0, out_price1}, {12'd0, exp1[19:0]});
          check("cmp1_sat",   {31'd0, out_sat1},   {31'd0, exp1[20]});
          check("cmp1_err",   {31'd0, out_err1},   {31'd0, exp1[21]});
        end
      end
      if (out_vld0) begin
        check("vld0_has_op", {31'd0, pending}, 32'd1);
        if (pending) begin
          check("cmp0_price", {12'd0, out_price0}, {12'd0, exp0[19:0]});
          check("cmp0_sat",   {31'd0, out_sat0},   {31'd0, exp0[20]});
          check("cmp0_err",   {31'd0, out_err0},   {31'd0, exp0[21]});
        end
      end
    end
  end

  task automatic do_op(input logic op, input logic [19:0] a, input logic [19:0] b,
                       input int hold,
                       output logic [19:0] p1, output logic s1, output logic e1,
                       output logic [19:0] p0, output logic s0, output logic e0);
    int n;
    int cyc;
    n = 0;
    while (!in_rdy1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_rdy_before_op", {31'd0, in_rdy1}, 32'd1);
    @(negedge clk);
    in_vld  = 1'b1;
    in_op   = op;
    in_a    = a;
    in_b    = b;
    out_rdy = (hold == 0);
    @(posedge clk);
    exp1    = model(op, a, b, 1'b1);
    exp0    = model(op, a, b, 1'b0);
    pending = 1'b1;
    #1;
    in_vld = 1'b0;
    in_op  = 1'($urandom);
    in_a   = 20'($urandom);
    in_b   = 20'($urandom);
    check("in_rdy_busy", {31'd0, in_rdy1}, 32'd0);
    cyc = 1;
    while (!out_vld1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd6);
    check("vld_pair", {31'd0, out_vld0}, {31'd0, out_vld1});
    p1 = out_price1; s1 = out_sat1; e1 = out_err1;
    p0 = out_price0; s0 = out_sat0; e0 = out_err0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("bp_vld_held", {31'd0, out_vld1}, 32'd1);
      check("bp_rdy_low",  {31'd0, in_rdy1},  32'd0);
      check("bp_price_stable", {12'd0, out_price1}, {12'd0, p1});
    end
    out_rdy = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1;
    check("vld_drop",  {31'd0, out_vld1 | out_vld0}, 32'd0);
    check("rdy_back",  {31'd0, in_rdy1 & in_rdy0},   32'd1);
    out_rdy = 1'b0;
  endtask

  logic [19:0] p1, p0, ra, rb;
  logic        s1, e1, s0, e0;

  initial begin
    arst_n  = 1'b0;
    in_vld  = 1'b0;
    in_op   = 1'b0;
    in_a    = '0;
    in_b    = '0;
    out_rdy = 1'b0;
    #12;
    check("rst_in_rdy",  {31'd0, in_rdy1},  32'd1);
    check("rst_out_vld", {31'd0, out_vld1}, 32'd0);
    check("rst_price",   {12'd0, out_price1}, 32'd0);
    check("rst_sat_err", {30'd0, out_sat1, out_err1}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    do_op(1'b0, 20'h12345, 20'h00067, 0, p1, s1, e1, p0, s0, e0);
    check("add_carry_price", {12'd0, p1}, 32'h12412);
    check("add_carry_sat",   {31'd0, s1}, 32'd0);
    check("add_carry_wrap",  {12'd0, p0}, 32'h12412);

    do_op(1'b0, 20'h99999, 20'h00001, 0, p1, s1, e1, p0, s0, e0);
    check("ovf_sat_price",  {12'd0, p1}, 32'h99999);
    check("ovf_sat_flag",   {31'd0, s1}, 32'd1);
    check("ovf_wrap_price", {12'd0, p0}, 32'h00000);
    check("ovf_wrap_flag",  {31'd0, s0}, 32'd1);

    do_op(1'b1, 20'h10000, 20'h00001, 2, p1, s1, e1, p0, s0, e0);
    check("sub_borrow_price", {12'd0, p1}, 32'h09999);
    check("sub_borrow_sat",   {31'd0, s1}, 32'd0);

    do_op(1'b1, 20'h00005, 20'h00010, 0, p1, s1, e1, p0, s0, e0);
    check("udf_sat_price",  {12'd0, p1}, 32'h00000);
    check("udf_sat_flag",   {31'd0, s1}, 32'd1);
    check("udf_wrap_price", {12'd0, p0}, 32'h99995);
    check("udf_wrap_flag",  {31'd0, s0}, 32'd1);

    do_op(1'b0, 20'h12A00, 20'h00000, 0, p1, s1, e1, p0, s0, e0);
    check("err_flag",       {31'd0, e1}, 32'd1);
    check("err_price",      {12'd0, p1}, 32'h00000);
    check("err_sat",        {31'd0, s1}, 32'd0);
    check("err_wrap_flag",  {31'd0, e0}, 32'd1);

    do_op(1'b0, 20'h99999, 20'h00000, 0, p1, s1, e1, p0, s0, e0);
    check("max_plus0_price", {12'd0, p1}, 32'h99999);
    check("max_plus0_sat",   {31'd0, s1}, 32'd0);

    do_op(1'b1, 20'h00000, 20'h00000, 0, p1, s1, e1, p0, s0, e0);
    check("zero_sub_price", {12'd0, p1}, 32'h00000);
    check("zero_sub_sat",   {31'd0, s1}, 32'd0);

    do_op(1'b1, 20'h45678, 20'h45678, 10, p1, s1, e1, p0, s0, e0);
    check("eq_sub_price", {12'd0, p1}, 32'h00000);
    check("eq_sub_sat",   {31'd0, s1}, 32'd0);

    do_op(1'b0, 20'h11111, 20'h22222, 0, p1, s1, e1, p0, s0, e0);
    check("plain_add_price", {12'd0, p1}, 32'h33333);

    // Reset in the middle of CALC (digit index 2).
    @(negedge clk);
    in_vld  = 1'b1;
    in_op   = 1'b0;
    in_a    = 20'h55555;
    in_b    = 20'h44444;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    check("midrst_in_rdy",  {31'd0, in_rdy1},  32'd1);
    check("midrst_out_vld", {31'd0, out_vld1 | out_vld0}, 32'd0);
    check("midrst_price",   {12'd0, out_price1}, 32'd0);
    check("midrst_sat_err", {30'd0, out_sat1, out_err1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n  = 1'b1;
    out_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_vld", {31'd0, out_vld1 | out_vld0}, 32'd0);
      check("post_rst_rdy",    {31'd0, in_rdy1},  32'd1);
    end
    do_op(1'b0, 20'h00050, 20'h00050, 0, p1, s1, e1, p0, s0, e0);
    check("post_rst_add", {12'd0, p1}, 32'h00100);

    // Randomized operations, checked by the compare process.
    for (int t = 0; t < 40; t++) begin
      int pos;
      ra = rand_bcd();
      rb = ($urandom_range(0, 5) == 0) ? ra : rand_bcd();
      if ($urandom_range(0, 7) == 0) begin
        pos = $urandom_range(0, 4);
        if ($urandom_range(0, 1) == 0) ra[pos*4 +: 4] = 4'($urandom_range(10, 15));
        else                           rb[pos*4 +: 4] = 4'($urandom_range(10, 15));
      end
      do_op(1'($urandom), ra, rb, $urandom_range(0, 3), p1, s1, e1, p0, s0, e0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_price_alu_seq.md
Name: bcd_price_alu_seq

Overview:
- Digit-serial BCD price arithmetic sequencer for the order-book datapath.
- Accepts one operation (price ± offset, both 5-digit BCD price_t) over a valid/ready handshake and walks the five BCD digits LSD-first, one per cycle, through a single 4-bit BCD add/sub cell.
- Saturates to PRICE_MAX / PRICE_MIN and presents the result on a valid/ready output.
- Used by the matching logic to compute tick-adjusted limit prices without a 20-bit parallel BCD adder.

Parameters:
- SAT_EN, 1, 1: saturate on overflow/underflow; 0: wrap modulo 100000 (flag still raised).
- N_DIGITS, 5, number of BCD digits; fixed to price_t layout (3 dollar + 2 cent); other values unsupported.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  operation request valid.
- in_rdy  out  1  block can accept an operation.
- in_op  in  1  0 = add (a + b), 1 = subtract (a − b).
- in_a  in  20  operand A, bcd_pkg::price_t.
- in_b  in  20  operand B, bcd_pkg::price_t.
- out_vld  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- out_price  out  20  result, bcd_pkg::price_t.
- out_sat  out  1  overflow (add) or underflow (sub) occurred.
- out_err  out  1  an operand contained a non-BCD digit (>9).

Behaviour:
- Reset (arst_n low, async): state = IDLE; in_rdy = 1; out_vld = 0; out_price = 'h000_00; out_sat = 0; out_err = 0; digit index = 0; carry/borrow = 0.
- States: IDLE, CALC, DONE.
- IDLE: in_rdy = 1.
  - On in_vld & in_rdy, capture in_op, in_a, in_b; check all 10 digits for >9 into a sticky err bit; clear carry/borrow; index = 0; go to CALC.
- CALC: in_rdy = 0, one digit per cycle at index i (0 = cents LSD, 4 = dollar MSD).
  - Add: s = a[i] + b[i] + c. If s > 9, digit = s − 10 and c = 1; else digit = s and c = 0.
  - Sub: d = a[i] − b[i] − c. If d < 0, digit = d + 10 and c = 1; else digit = d and c = 0.
  - Digit is written into the result shift/holding register at position i.
  - After i = 4, go to DONE. The final c is the overflow/borrow indicator.
- DONE: out_vld = 1, registered outputs stable and held until out_rdy.
  - Final c = 1 with add: out_sat = 1; out_price = PRICE_MAX ('h999_99) if SAT_EN, else the wrapped digits.
  - Final c = 1 with sub: out_sat = 1; out_price = PRICE_MIN ('h000_00) if SAT_EN, else the wrapped (ten's-complement) digits.
  - err set: out_err = 1, out_sat = 0, out_price = 'h000_00, regardless of SAT_EN.
  - On out_vld & out_rdy, go to IDLE; out_vld deasserts next cycle.
- Latency: accept edge T → CALC cycles T+1..T+5 → out_vld high from T+6.
- Throughput: one operation per 7 cycles minimum (no accept while in DONE; no bypass DONE→CALC).
- Handshake rules:
  - in_rdy is a function of state only; no combinational path from in_vld or out_rdy to in_rdy.
  - out_vld never drops without out_rdy.
  - out_price, out_sat and out_err are constant while out_vld = 1.
- Inputs are ignored outside IDLE; in_a and in_b need only be stable in the accept cycle.
- out_rdy held high before out_vld: the result is accepted in its first valid cycle.
- Reset asserted mid-CALC or mid-DONE: the operation is abandoned, with no output pulse after release; the block resumes in IDLE with in_rdy = 1.
- Boundaries:
  - 999.99 + 000.00 = 999.99, no sat.
  - 000.00 − 000.00 = 000.00, no sat.
  - Equal operands on subtract yield 000.00, no sat.

Test Plan:
- Add with carry chain: in_a='h123_45, in_b='h000_67, op=0 → out_price='h124_12, out_sat=0, out_vld exactly 6 cycles after accept.
- Add overflow: in_a='h999_99, in_b='h000_01, op=0, SAT_EN=1 → 'h999_99, out_sat=1; with SAT_EN=0 → 'h000_00, out_sat=1.
- Sub borrow and underflow: 'h100_00 − 'h000_01 → 'h099_99, sat=0; then 'h000_05 − 'h000_10 with SAT_EN=1 → 'h000_00, sat=1.
- Invalid digit: in_a='h12A_00 → out_err=1, out_price='h000_00, out_sat=0.
- Back-pressure: hold out_rdy=0 for 10 cycles after out_vld → outputs stable and in_rdy=0 throughout; raise out_rdy → out_vld drops and in_rdy=1 next cycle; a new request is accepted then.
- Reset mid-operation: drop arst_n at CALC index 2 → all outputs at reset values immediately; after release, no out_vld until a new request; next op 'h000_50+'h000_50 → 'h001_00.
